ifs_capture_sched: RTL and testbench
====================================

# ifs_capture_sched

Capture scheduler for a bank of ECP3 input registers with synchronous preset and clock enable (SP/PD style cells). Several requesters share one physical input-register bank. The block arbitrates round-robin between them and sequences the bank: preset, settle, capture and sample. It returns the captured word tagged with the winning requester. It sits between the I/O ring register bank and the fabric consumers of sampled pins.

## Interface
Parameters:
- NREQ, 4: number of requesters, 2..16.
- WIDTH, 8: lanes in the controlled input-register bank.
- SETTLE, 2: idle cycles between preset and capture, 0..15.

Ports:
- SCLK  in  1  clock, rising edge; the same clock drives the register bank.
- RSTN  in  1  reset, asynchronous and active-low.
- REQ  in  NREQ  per-requester capture request, level.
- GNT  out  NREQ  one-hot grant, held for the whole transaction.
- SP  out  1  clock enable to the bank.
- PD  out  1  synchronous preset to the bank.
- Q_IN  in  WIDTH  Q outputs of the bank.
- DOUT  out  WIDTH  captured word.
- DVALID  out  1  one-cycle strobe; DOUT and DOWNER are valid while it is high.
- DOWNER  out  clog2(NREQ)  index of the requester that owns DOUT.

## Operation
- Reset values: GNT=0, SP=0, PD=0, DOUT=0, DVALID=0, DOWNER=0, round-robin pointer=0, state IDLE.
- All outputs are registered.
- State machine:
  - IDLE: if any REQ bit is set, pick a winner, latch GNT and DOWNER, go to PRESET.
  - PRESET: PD=1 and SP=1 for exactly one cycle, so the bank loads all-ones. Then go to SETTLE, or to CAPTURE if SETTLE=0.
  - SETTLE: SP=0, PD=0. Stay SETTLE cycles, counted by a down-counter of width clog2(SETTLE+1). Then go to CAPTURE.
  - CAPTURE: SP=1, PD=0 for one cycle.
  - SAMPLE: Q_IN now reflects the captured pins. Register DOUT<=Q_IN and go to IDLE. DVALID=1 and GNT=0 in the following cycle.
- Arbitration:
  - The winner is the first set REQ bit at or above pointer, wrapping modulo NREQ.
  - After a grant, the pointer becomes winner+1, mod NREQ.
  - The first grant after reset favours requester 0.
- REQ dropped mid-transaction: the transaction completes normally and DVALID is still issued. There is no abort.
- REQ is ignored outside IDLE. The DVALID cycle is an IDLE cycle and does arbitrate.
- A requester that holds REQ high gets repeated captures, subject to round-robin fairness.
- Reset mid-transaction: all outputs return to reset values immediately and asynchronously. No DVALID is produced. SP and PD are deasserted, so the bank keeps whatever it last loaded.

## Timing
- REQ high in cycle 0 (sampled at the end of cycle 0), preset build:
  - cycle 1: PRESET, GNT asserted.
  - cycles 2..1+SETTLE: SETTLE.
  - cycle 2+SETTLE: CAPTURE.
  - cycle 3+SETTLE: SAMPLE.
  - cycle 4+SETTLE: DVALID.
- Request-to-DVALID latency is SETTLE+4. With the default SETTLE=2, DVALID arrives in cycle 6.
- Back-to-back transaction period is SETTLE+4 cycles, because the DVALID cycle arbitrates the next grant.
- GNT is high from PRESET through SAMPLE inclusive.
- SP and PD are never asserted in IDLE or SETTLE.

## Configuration
- IFS_CAPTURE_PRESET_EN defined: full sequence as above.
- IFS_CAPTURE_PRESET_EN undefined:
  - PRESET and SETTLE states are removed and the SETTLE parameter is ignored.
  - PD is tied to 0.
  - IDLE goes directly to CAPTURE: CAPTURE in cycle 1, SAMPLE in cycle 2, DVALID in cycle 3.
  - Latency is 3 and the period is 3.

## Structure
- Shared package ifs_capture_pkg holds:
  - the state enum (IDLE, PRESET, SETTLE, CAPTURE, SAMPLE);
  - a localparam function for clog2.
- One sub-module, ifs_rr_arb: combinational round-robin pick from REQ and the pointer, producing a one-hot vector and an index. The pointer register stays in the parent.

## Test plan
- Reset check: hold RSTN=0 with REQ=4'b1111, then release → all outputs stay 0 until the first edge after release, and the first GNT=4'b0001.
- Single request, SETTLE=2, preset build, REQ=4'b0100 in cycle 0 and pins 8'hA5 →
  - PD=1 and SP=1 in cycle 1;
  - SP=1 alone in cycle 4;
  - DVALID=1 in cycle 6 with DOUT=8'hA5 and DOWNER=2.
- Fairness: REQ=4'b1111 held → DOWNER sequence 0,1,2,3,0, with one DVALID every 6 cycles.
- Abandon: REQ[1] dropped during SETTLE → transaction still completes with DOWNER=1 and DVALID high.
- Reset mid-CAPTURE: RSTN=0 in cycle 4 → SP=0 and GNT=0 immediately, no DVALID, pointer back to 0.
- Build without IFS_CAPTURE_PRESET_EN, REQ=4'b0001 → PD is never asserted, SP=1 in cycle 1, DVALID in cycle 3.

Source files
------------

// File: rtl/ifs_capture_pkg.sv
// Shared types and elaboration helpers for the input-register capture scheduler.
package ifs_capture_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_PRESET  = 3'd1,
    ST_SETTLE  = 3'd2,
    ST_CAPTURE = 3'd3,
    ST_SAMPLE  = 3'd4
  } state_t;

  // Ceiling log2, usable in parameter and port-width expressions.
  function automatic int clog2(input int value);
    int r;
    r = 32'sd0;
    for (int v = value - 32'sd1; v > 32'sd0; v = v / 32'sd2) begin
      r = r + 32'sd1;
    end
    return r;
  endfunction

endpackage

// File: rtl/ifs_rr_arb.sv
// Combinational round-robin pick: first set request at or above the pointer,
// wrapping modulo NREQ. Returns a one-hot grant, its index and an any-request flag.
module ifs_rr_arb
  import ifs_capture_pkg::*;
#(
  parameter int NREQ = 4
) (
  input  logic [NREQ-1:0]        i_req,
  input  logic [clog2(NREQ)-1:0] i_ptr,
  output logic [NREQ-1:0]        o_gnt,
  output logic [clog2(NREQ)-1:0] o_idx,
  output logic                   o_any
);

  localparam int IDX_W = clog2(NREQ);

  logic [IDX_W-1:0] w_cand;

  // Scan candidates in priority order starting from the pointer.
  always_comb begin
    o_gnt  = '0;
    o_idx  = '0;
    o_any  = 1'b0;
    w_cand = '0;
    for (int k = 0; k < NREQ; k++) begin
      w_cand = IDX_W'((int'(i_ptr) + k) % NREQ);
      if (!o_any && i_req[w_cand]) begin
        o_any         = 1'b1;
        o_gnt[w_cand] = 1'b1;
        o_idx         = w_cand;
      end else begin
        o_any = o_any;
      end
    end
  end

endmodule

// File: rtl/ifs_capture_sched.sv
// Capture scheduler for a shared SP/PD input-register bank: round-robin grant,
// then preset / settle / capture / sample. Optional preset phase: IFS_CAPTURE_PRESET_EN.
module ifs_capture_sched
  import ifs_capture_pkg::*;
#(
  parameter int NREQ   = 4,
  parameter int WIDTH  = 8,
  parameter int SETTLE = 2
) (
  input  logic                   SCLK,
  input  logic                   RSTN,
  input  logic [NREQ-1:0]        REQ,
  output logic [NREQ-1:0]        GNT,
  output logic                   SP,
  output logic                   PD,
  input  logic [WIDTH-1:0]       Q_IN,
  output logic [WIDTH-1:0]       DOUT,
  output logic                   DVALID,
  output logic [clog2(NREQ)-1:0] DOWNER
);

  localparam int IDX_W = clog2(NREQ);

  state_t           r_state;
  logic [IDX_W-1:0] r_ptr;
  logic [NREQ-1:0]  r_gnt;
  logic             r_sp;
  logic             r_pd;
  logic [WIDTH-1:0] r_dout;
  logic             r_dvalid;
  logic [IDX_W-1:0] r_owner;

  logic [NREQ-1:0]  w_gnt;
  logic [IDX_W-1:0] w_idx;
  logic             w_any;
  logic [IDX_W-1:0] w_ptr_nxt;

`ifdef IFS_CAPTURE_PRESET_EN
  localparam int CNT_W = (clog2(SETTLE + 1) < 1) ? 1 : clog2(SETTLE + 1);
  logic [CNT_W-1:0] r_cnt;
`else
  logic w_unused_settle;
  assign w_unused_settle = (SETTLE != 32'sd0);
`endif

  ifs_rr_arb #(
    .NREQ (NREQ)
  ) u_arb (
    .i_req (REQ),
    .i_ptr (r_ptr),
    .o_gnt (w_gnt),
    .o_idx (w_idx),
    .o_any (w_any)
  );

  assign w_ptr_nxt = (w_idx == IDX_W'(NREQ - 1)) ? '0 : (w_idx + IDX_W'(1));

  // Transaction sequencer; every output is a register updated on state transitions.
  always_ff @(posedge SCLK or negedge RSTN) begin
    if (!RSTN) begin
      r_state  <= ST_IDLE;
      r_ptr    <= '0;
      r_gnt    <= '0;
      r_sp     <= 1'b0;
      r_pd     <= 1'b0;
      r_dout   <= '0;
      r_dvalid <= 1'b0;
      r_owner  <= '0;
`ifdef IFS_CAPTURE_PRESET_EN
      r_cnt    <= '0;
`endif
    end else begin
      r_dvalid <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_any) begin
            r_gnt   <= w_gnt;
            r_owner <= w_idx;
            r_ptr   <= w_ptr_nxt;
            r_sp    <= 1'b1;
`ifdef IFS_CAPTURE_PRESET_EN
            r_pd    <= 1'b1;
            r_state <= ST_PRESET;
`else
            r_state <= ST_CAPTURE;
`endif
          end else begin
            r_state <= ST_IDLE;
          end
        end
`ifdef IFS_CAPTURE_PRESET_EN
        ST_PRESET: begin
          r_pd <= 1'b0;
          if (SETTLE == 32'sd0) begin
            r_sp    <= 1'b1;
            r_state <= ST_CAPTURE;
          end else begin
            r_sp    <= 1'b0;
            r_cnt   <= CNT_W'(SETTLE);
            r_state <= ST_SETTLE;
          end
        end
        ST_SETTLE: begin
          if (r_cnt <= CNT_W'(1)) begin
            r_sp    <= 1'b1;
            r_state <= ST_CAPTURE;
          end else begin
            r_cnt   <= r_cnt - CNT_W'(1);
          end
        end
`endif
        ST_CAPTURE: begin
          r_sp    <= 1'b0;
          r_pd    <= 1'b0;
          r_state <= ST_SAMPLE;
        end
        // Bank was clocked at the end of CAPTURE, so Q_IN now holds the pins.
        ST_SAMPLE: begin
          r_dout   <= Q_IN;
          r_dvalid <= 1'b1;
          r_gnt    <= '0;
          r_state  <= ST_IDLE;
        end
        default: begin
          r_sp    <= 1'b0;
          r_pd    <= 1'b0;
          r_gnt   <= '0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign GNT    = r_gnt;
  assign SP     = r_sp;
  assign PD     = r_pd;
  assign DOUT   = r_dout;
  assign DVALID = r_dvalid;
  assign DOWNER = r_owner;

endmodule

// File: tb/tb_ifs_capture_sched.sv
// Directed self-checking bench for ifs_capture_sched; expectations follow the
// preset or no-preset build selected by IFS_CAPTURE_PRESET_EN.
module tb_ifs_capture_sched;

  localparam int NREQ   = 4;
  localparam int WIDTH  = 8;
  localparam int SETTLE = 2;
`ifdef IFS_CAPTURE_PRESET_EN
  localparam bit PRE = 1'b1;
`else
  localparam bit PRE = 1'b0;
`endif
  localparam int LAT = PRE ? (SETTLE + 4) : 3;

  logic       clk  = 1'b0;
  logic       rstn = 1'b0;
  logic [3:0] req  = 4'b0000;
  logic [3:0] gnt;
  logic       sp;
  logic       pd;
  logic [7:0] q_in = 8'h00;
  logic [7:0] dout;
  logic       dvalid;
  logic [1:0] downer;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  ifs_capture_sched #(
    .NREQ   (NREQ),
    .WIDTH  (WIDTH),
    .SETTLE (SETTLE)
  ) dut (
    .SCLK   (clk),
    .RSTN   (rstn),
    .REQ    (req),
    .GNT    (gnt),
    .SP     (sp),
    .PD     (pd),
    .Q_IN   (q_in),
    .DOUT   (dout),
    .DVALID (dvalid),
    .DOWNER (downer)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [3:0] onehot(input int i);
    logic [3:0] one;
    one = 4'b0001;
    return one << i;
  endfunction

  task automatic do_reset();
    rstn = 1'b0;
    req  = 4'b0000;
    q_in = 8'h3C;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rstn = 1'b1;
  endtask

  initial begin
    // Reset with all requests pending, then release.
    rstn = 1'b0;
    req  = 4'b1111;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_gnt",    32'(gnt),    32'd0);
    chk("rst_sp",     32'(sp),     32'd0);
    chk("rst_pd",     32'(pd),     32'd0);
    chk("rst_dout",   32'(dout),   32'd0);
    chk("rst_dvalid", 32'(dvalid), 32'd0);
    chk("rst_downer", 32'(downer), 32'd0);
    @(negedge clk);
    rstn = 1'b1;
    #1;
    chk("rel_gnt", 32'(gnt), 32'd0);
    chk("rel_sp",  32'(sp),  32'd0);
    @(posedge clk);
    #1;
    chk("first_gnt", 32'(gnt), 32'(4'b0001));
    chk("first_sp",  32'(sp),  32'd1);
    chk("first_pd",  32'(pd),  32'(PRE));

    // Single request from requester 2; pins show A5 only while sampled.
    do_reset();
    req = 4'b0100;
    for (int k = 1; k <= LAT + 1; k++) begin
      @(posedge clk);
      #1;
      req  = 4'b0000;
      q_in = (k == LAT - 1) ? 8'hA5 : 8'h3C;
      chk("single_gnt", 32'(gnt),    (k <= LAT - 1) ? 32'(4'b0100) : 32'd0);
      chk("single_sp",  32'(sp),     32'((k == 1) || (k == LAT - 2)));
      chk("single_pd",  32'(pd),     32'(PRE && (k == 1)));
      chk("single_dv",  32'(dvalid), 32'(k == LAT));
      if (k == LAT) begin
        chk("single_dout",   32'(dout),   32'(8'hA5));
        chk("single_downer", 32'(downer), 32'd2);
      end
    end

    // All requesters held: round-robin 0,1,2,3,0 with one strobe per period.
    do_reset();
    req = 4'b1111;
    for (int k = 1; k <= 5 * LAT; k++) begin
      @(posedge clk);
      #1;
      if ((k % LAT) == 0) begin
        chk("fair_dv",     32'(dvalid), 32'd1);
        chk("fair_downer", 32'(downer), 32'(((k - 1) / LAT) % 4));
        chk("fair_gnt_off", 32'(gnt),   32'd0);
      end else begin
        chk("fair_dv_off", 32'(dvalid), 32'd0);
      end
      if ((k % LAT) == 1) begin
        chk("fair_gnt", 32'(gnt), 32'(onehot(((k - 1) / LAT) % 4)));
      end
    end

    // Requester 1 drops its request mid-transaction; capture still completes.
    do_reset();
    req = 4'b0010;
    for (int k = 1; k <= LAT; k++) begin
      @(posedge clk);
      #1;
      if (k == (PRE ? 2 : 1)) begin
        req = 4'b0000;
      end
      chk("drop_dv", 32'(dvalid), 32'(k == LAT));
      if (k == LAT) begin
        chk("drop_downer", 32'(downer), 32'd1);
      end else begin
        chk("drop_gnt", 32'(gnt), 32'(4'b0010));
      end
    end
    @(posedge clk);
    #1;
    chk("drop_idle_gnt", 32'(gnt), 32'd0);

    // Reset asserted while in CAPTURE: outputs clear at once, pointer restarts.
    do_reset();
    req = 4'b1111;
    for (int k = 1; k <= LAT - 2; k++) begin
      @(posedge clk);
      #1;
    end
    chk("cap_sp",  32'(sp),  32'd1);
    chk("cap_gnt", 32'(gnt), 32'(4'b0001));
    #2;
    rstn = 1'b0;
    #1;
    chk("arst_sp",  32'(sp),     32'd0);
    chk("arst_gnt", 32'(gnt),    32'd0);
    chk("arst_pd",  32'(pd),     32'd0);
    chk("arst_dv",  32'(dvalid), 32'd0);
    repeat (3) begin
      @(posedge clk);
      #1;
      chk("arst_hold_dv",  32'(dvalid), 32'd0);
      chk("arst_hold_gnt", 32'(gnt),    32'd0);
    end
    @(negedge clk);
    rstn = 1'b1;
    @(posedge clk);
    #1;
    chk("arst_ptr_gnt", 32'(gnt), 32'(4'b0001));

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
